// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Does one shift-add or restoring shift-subtract step per cycle, then a sign fix-up cycle.
module mdu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, mul_top, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy = (state != IDLE);

  // op[0] set means unsigned, so signed magnitudes are only taken for MULT/DIV.
  always_comb begin
    a_neg    = ~op[0] & src_a[WIDTH-1];
    b_neg    = ~op[0] & src_b[WIDTH-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    add_sum  = acc_hi + {1'b0, opnd};
    mul_top  = acc_lo[0] ? add_sum : acc_hi;
    shifted  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    prod     = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  end

  // NOTE: every register here is state, so each is assigned with <= only; the
  // datapath registers are reset too so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CALC;
            cnt      <= '0;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op[1] & (src_b == '0);
            a_raw    <= src_a;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            opnd     <= op[1] ? b_mag : a_mag;
          end else begin
            if (hi_we) hi_o <= src_a;
            if (lo_we) lo_o <= src_a;
          end
        end
        CALC: begin
          if (is_div) begin
            // Restoring step: a clear borrow bit means the trial subtraction fits.
            if (!diff[WIDTH]) begin
              acc_hi <= diff;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= shifted;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= {1'b0, mul_top[WIDTH:1]};
            acc_lo <= {mul_top[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi_o <= prod_fix[2*WIDTH-1:WIDTH];
            lo_o <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_o <= a_raw;
            lo_o <= '1;
          end else begin
            hi_o <= rem_fix;
            lo_o <= quo_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: transaction-level reference model compared every
// cycle, directed corner cases with literal expectations, then randomized operations.
module tb_mdu_unit;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] hi_o, lo_o;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  // Reference model state: committed HI/LO, cycles left in the operation, pending result.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_cnt  = 0;
  logic        m_done = 1'b0;

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_o  (hi_o),
    .lo_o  (lo_o),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 0) begin h = a; l = '1; end
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
      end else if (start) begin
        ref_op(op, src_a, src_b, p_hi, p_lo);
        m_cnt = WIDTH + 1;
      end else begin
        if (hi_we) m_hi = src_a;
        if (lo_we) m_lo = src_a;
      end
    end
  end

  always @(negedge clk) begin
    check("hi_o", hi_o, m_hi);
    check("lo_o", lo_o, m_lo);
    check("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
    check("done", {31'b0, done}, {31'b0, m_done});
  end

  // Returns at the negedge of the done cycle (or after a mid-op reset when rst_c > 0).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int rst_c, input bit noise);
    bit seen   = 1'b0;
    int busy_n = 0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    hi_we = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    lo_we = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        break;
      end
      if (busy) busy_n++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op    = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      hi_we = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      lo_we = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == inj) begin start = 1'b1; op = 2'b10; hi_we = 1'b1; src_a = 32'hDEAD; end
      if (c == rst_c) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midop_rst_hi", hi_o, 32'h0);
        check("midop_rst_lo", lo_o, 32'h0);
        check("midop_rst_busy", {31'b0, busy}, 32'h0);
        check("midop_rst_done", {31'b0, done}, 32'h0);
        @(negedge clk) rst = 1'b0;
        return;
      end
    end
    check("done_seen", {31'b0, seen}, 32'h1);
    check("busy_cycles", busy_n, 33);
  endtask

  task automatic idle_write(input logic h, input logic l, input logic [31:0] a);
    @(negedge clk);
    hi_we = h; lo_we = l; src_a = a;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic expect_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
    check({name, "_hi"}, hi_o, h);
    check({name, "_lo"}, lo_o, l);
  endtask

  initial begin
    bit          saw;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_hilo("reset", 32'h0, 32'h0);

    idle_write(1'b1, 1'b1, 32'hCAFE);
    expect_hilo("both_we", 32'hCAFE, 32'hCAFE);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expect_hilo("async_rst", 32'h0, 32'h0);
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    check("async_rst_done", {31'b0, done}, 32'h0);
    @(negedge clk) rst = 1'b0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, 1'b0);
    expect_hilo("multu_max", 32'hFFFFFFFE, 32'h00000001);
    check("multu_done_pulse", {31'b0, done}, 32'h1);
    @(negedge clk);
    check("multu_done_drop", {31'b0, done}, 32'h0);

    run_op(2'b00, -32'sd3, 32'd5, -1, -1, 1'b0);
    expect_hilo("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(2'b10, -32'sd7, 32'd2, -1, -1, 1'b0);
    expect_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'b11, 32'd100, 32'd7, -1, -1, 1'b0);
    expect_hilo("divu", 32'd2, 32'd14);
    run_op(2'b11, 32'h64, 32'h0, -1, -1, 1'b0);
    expect_hilo("divu_zero", 32'h64, 32'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, -1, 1'b0);
    expect_hilo("div_ovf", 32'h0, 32'h80000000);

    run_op(2'b01, 32'd2, 32'd3, 5, -1, 1'b0);
    expect_hilo("collide", 32'h0, 32'd6);
    idle_write(1'b1, 1'b0, 32'h1234);
    expect_hilo("mthi", 32'h1234, 32'd6);

    run_op(2'b01, 32'd7, 32'd9, -1, 10, 1'b0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("no_done_after_rst", {31'b0, saw}, 32'h0);
    expect_hilo("after_rst", 32'h0, 32'h0);
    run_op(2'b01, 32'd7, 32'd9, -1, -1, 1'b0);
    expect_hilo("restart", 32'h0, 32'd63);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
        2: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(ro, ra, rb, -1, -1, 1'b1);
      if ($urandom_range(0, 2) == 0)
        idle_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
